// File: rtl/rnn_param_mem.sv
// Parameter/result memory beside the RNN core: zero-wait reads of the weight, bias and
// T regions, host load port, and a result FIFO drained by a valid/ready stream.
module rnn_param_mem #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mce,
    input  logic [2:0]  msel,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    output logic [19:0] mdata_r,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  ld_sel,
    input  logic [16:0] ld_addr,
    input  logic [19:0] ld_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_addr,
    output logic [19:0] out_data,
    output logic        ovf,
    output logic        err,
    input  logic        flag_clr
);

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 20;
    localparam int unsigned EW = AW + DW;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] SEL_WX  = 3'b000;
    localparam logic [2:0] SEL_BX  = 3'b001;
    localparam logic [2:0] SEL_WH  = 3'b010;
    localparam logic [2:0] SEL_BH  = 3'b011;
    localparam logic [2:0] SEL_T   = 3'b100;
    localparam logic [2:0] SEL_RES = 3'b101;

    // True when the address lies inside a readable/loadable region.
    function automatic logic addr_ok(input logic [2:0] sel, input logic [16:0] a);
        logic ok;
        ok = 1'b0;
        case (sel)
            SEL_WX:         ok = (a[16:11] == 6'd0);
            SEL_BX, SEL_BH: ok = (a[16:6] == 11'd0);
            SEL_WH:         ok = (a[16:12] == 5'd0);
            SEL_T:          ok = (a == 17'd0);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [DW-1:0] wx_mem [2048];
    logic [DW-1:0] wh_mem [4096];
    logic [DW-1:0] bx_mem [64];
    logic [DW-1:0] bh_mem [64];

    logic [DW-1:0] t_q, t_d;
    logic [EW-1:0] fifo_q [DEPTH];
    logic [EW-1:0] fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [EW-1:0] head_q, head_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic rd_ok, ld_fire, ld_ok, ld_we;
    logic push, pop, full, push_ok, ovf_set, err_set;

    // Zero-wait read mux, independent of mce.
    always_comb begin
        mdata_r = '0;
        rd_ok   = addr_ok(msel, maddr);
        if (rd_ok) begin
            case (msel)
                SEL_WX:  mdata_r = wx_mem[maddr[10:0]];
                SEL_BX:  mdata_r = bx_mem[maddr[5:0]];
                SEL_WH:  mdata_r = wh_mem[maddr[11:0]];
                SEL_BH:  mdata_r = bh_mem[maddr[5:0]];
                SEL_T:   mdata_r = t_q;
                default: mdata_r = '0;
            endcase
        end
    end

    always_comb begin
        ld_ready = ~mce;
        ld_fire  = ld_valid & ~mce;
        ld_ok    = addr_ok(ld_sel, ld_addr);
        ld_we    = ld_fire & ld_ok;
        t_d      = (ld_we && (ld_sel == SEL_T)) ? ld_data : t_q;
    end

    // Parameter arrays are never reset; they keep their contents across reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            case (ld_sel)
                SEL_WX:  wx_mem[ld_addr[10:0]] <= ld_data;
                SEL_BX:  bx_mem[ld_addr[5:0]]  <= ld_data;
                SEL_WH:  wh_mem[ld_addr[11:0]] <= ld_data;
                SEL_BH:  bh_mem[ld_addr[5:0]]  <= ld_data;
                default: ;
            endcase
        end
    end

    // Result FIFO and sticky flags; a full FIFO still accepts a push when it pops.
    always_comb begin
        push     = mce & (msel == SEL_RES);
        pop      = valid_q & out_ready;
        full     = (cnt_q == CW'(DEPTH));
        push_ok  = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        err_set  = (mce & ~push & ~rd_ok) | (ld_fire & ~ld_ok);

        fifo_d   = fifo_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = {maddr, mdata_w};
        end
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
        valid_d  = (cnt_d != '0);
        head_d   = fifo_d[rd_ptr_d];

        ovf_d    = ovf_set | (ovf_q & ~flag_clr);
        err_d    = err_set | (err_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            t_q      <= t_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = head_q[EW-1:DW];
    assign out_data  = head_q[DW-1:0];
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rnn_param_mem.sv
// Bench for rnn_param_mem: directed checks with literal expectations, then random
// traffic compared every cycle against a queue/array model of the memory.
module tb_rnn_param_mem;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic [19:0] mdata_r;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_sel;
    logic [16:0] ld_addr;
    logic [19:0] ld_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_addr;
    logic [19:0] out_data;
    logic        ovf;
    logic        err;
    logic        flag_clr;

    rnn_param_mem #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mce(mce), .msel(msel), .maddr(maddr),
        .mdata_w(mdata_w), .mdata_r(mdata_r), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .ovf(ovf),
        .err(err), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    typedef struct {
        logic [16:0] a;
        logic [19:0] d;
    } ent_t;

    logic [19:0] wx [2048];
    logic [19:0] wh [4096];
    logic [19:0] bx [64];
    logic [19:0] bh [64];
    bit          wxv [2048];
    bit          whv [4096];
    bit          bxv [64];
    bit          bhv [64];
    logic [19:0] tm;
    ent_t        q[$];
    bit          m_ovf;
    bit          m_err;

    task automatic chk(input string name, input logic [36:0] got, input logic [36:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] s, input logic [16:0] a);
        case (s)
            3'd0:       return a < 17'd2048;
            3'd1, 3'd3: return a < 17'd64;
            3'd2:       return a < 17'd4096;
            3'd4:       return a == 17'd0;
            default:    return 1'b0;
        endcase
    endfunction

    // Expected read value; returns 0 when the location was never loaded.
    function automatic bit exp_rd(input logic [2:0] s, input logic [16:0] a, output logic [19:0] v);
        v = '0;
        if (!legal(s, a)) return 1'b1;
        case (s)
            3'd0:    begin v = wx[a[10:0]]; return wxv[a[10:0]]; end
            3'd1:    begin v = bx[a[5:0]];  return bxv[a[5:0]];  end
            3'd2:    begin v = wh[a[11:0]]; return whv[a[11:0]]; end
            3'd3:    begin v = bh[a[5:0]];  return bhv[a[5:0]];  end
            default: begin v = tm;          return 1'b1;         end
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        tm    = '0;
    endtask

    task automatic model_step();
        bit pop, push, full, oset, eset, ld_ok;
        if (!reset) return;
        pop   = (q.size() != 0) && out_ready;
        push  = mce && (msel == 3'd5);
        full  = (q.size() == DEPTH);
        oset  = push && full && !pop;
        ld_ok = !mce && ld_valid && legal(ld_sel, ld_addr);
        eset  = (mce && (msel != 3'd5) && !legal(msel, maddr)) ||
                (!mce && ld_valid && !legal(ld_sel, ld_addr));
        if (pop) void'(q.pop_front());
        if (push && !oset) q.push_back('{a: maddr, d: mdata_w});
        if (ld_ok) begin
            case (ld_sel)
                3'd0:    begin wx[ld_addr[10:0]] = ld_data; wxv[ld_addr[10:0]] = 1'b1; end
                3'd1:    begin bx[ld_addr[5:0]]  = ld_data; bxv[ld_addr[5:0]]  = 1'b1; end
                3'd2:    begin wh[ld_addr[11:0]] = ld_data; whv[ld_addr[11:0]] = 1'b1; end
                3'd3:    begin bh[ld_addr[5:0]]  = ld_data; bhv[ld_addr[5:0]]  = 1'b1; end
                default: tm = ld_data;
            endcase
        end
        m_ovf = oset ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
        m_err = eset ? 1'b1 : (flag_clr ? 1'b0 : m_err);
    endtask

    // Single compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [19:0] v;
        bit          known;
        chk("out_valid", 37'(out_valid), 37'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_addr", 37'(out_addr), 37'(q[0].a));
            chk("out_data", 37'(out_data), 37'(q[0].d));
        end
        chk("ovf", 37'(ovf), 37'(m_ovf));
        chk("err", 37'(err), 37'(m_err));
        chk("ld_ready", 37'(ld_ready), 37'(!mce));
        known = exp_rd(msel, maddr, v);
        if (known) chk("mdata_r", 37'(mdata_r), 37'(v));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input logic [2:0] s, input logic [16:0] a, input logic [19:0] d);
        ld_valid = 1'b1;
        ld_sel   = s;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic push_word(input logic [16:0] a, input logic [19:0] d);
        mce     = 1'b1;
        msel    = 3'd5;
        maddr   = a;
        mdata_w = d;
        tick();
    endtask

    function automatic logic [16:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 17'($urandom_range(0, 7));
            1:       return 17'($urandom_range(63, 64));
            2:       return 17'($urandom_range(2047, 2048));
            3:       return 17'($urandom_range(4095, 4096));
            default: return 17'($urandom);
        endcase
    endfunction

    initial begin
        logic [19:0] exp6 [4];
        exp6 = '{20'h00012, 20'h00013, 20'h00014, 20'h00009};

        reset = 1'b0; mce = 1'b0; msel = 3'd4; maddr = '0; mdata_w = '0;
        ld_valid = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
        out_ready = 1'b0; flag_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 37'(out_valid), 37'(0));
        chk("rst_out_addr", 37'(out_addr), 37'(0));
        chk("rst_out_data", 37'(out_data), 37'(0));
        chk("rst_ovf", 37'(ovf), 37'(0));
        chk("rst_err", 37'(err), 37'(0));
        chk("rst_t", 37'(mdata_r), 37'(0));
        tick();
        reset = 1'b1;
        tick();

        // Loads then zero-wait reads
        load(3'd0, 17'd5, 20'h12345);
        load(3'd2, 17'd4095, 20'hFFFFF);
        load(3'd4, 17'd0, 20'h00003);
        load(3'd0, 17'd6, 20'h00111);
        mce = 1'b1; msel = 3'd0; maddr = 17'd5; #1;
        chk("rd_wx5", 37'(mdata_r), 37'(20'h12345));
        msel = 3'd2; maddr = 17'd4095; #1;
        chk("rd_wh4095", 37'(mdata_r), 37'(20'hFFFFF));
        msel = 3'd4; maddr = 17'd0; #1;
        chk("rd_t", 37'(mdata_r), 37'(3));
        tick();
        chk("err_clean", 37'(err), 37'(0));

        // Out-of-range read sets err only with mce
        msel = 3'd1; maddr = 17'd64; #1;
        chk("rd_bx64", 37'(mdata_r), 37'(0));
        tick();
        chk("err_set", 37'(err), 37'(1));
        mce = 1'b0; flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        tick();
        chk("err_clr", 37'(err), 37'(0));
        chk("err_idle_rd", 37'(err), 37'(0));

        // Load blocked while the RNN runs
        mce = 1'b1; msel = 3'd0; maddr = 17'd6;
        ld_valid = 1'b1; ld_sel = 3'd0; ld_addr = 17'd6; ld_data = 20'hABCDE; #1;
        chk("ld_ready_busy", 37'(ld_ready), 37'(0));
        tick();
        chk("ld_blocked", 37'(mdata_r), 37'(20'h00111));
        mce = 1'b0;
        tick();
        ld_valid = 1'b0; #1;
        chk("ld_accepted", 37'(mdata_r), 37'(20'hABCDE));

        // Overflow: five pushes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) push_word(17'(32'h40 + i), 20'(i + 1));
        mce = 1'b0; msel = 3'd0; maddr = '0; #1;
        chk("ovf_set", 37'(ovf), 37'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", 37'(out_addr), 37'(32'h40 + i));
            chk("drain_data", 37'(out_data), 37'(i + 1));
            tick();
        end
        chk("drain_empty", 37'(out_valid), 37'(0));
        out_ready = 1'b0; flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0; #1;
        chk("ovf_clr", 37'(ovf), 37'(0));

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) push_word(17'(32'h50 + i), 20'(32'h11 + i));
        out_ready = 1'b1;
        push_word(17'h0005F, 20'h9);
        mce = 1'b0; msel = 3'd0; maddr = '0; #1;
        chk("full_pp_ovf", 37'(ovf), 37'(0));
        for (int i = 0; i < 4; i++) begin
            chk("full_pp_valid", 37'(out_valid), 37'(1));
            chk("full_pp_data", 37'(out_data), 37'(exp6[i]));
            tick();
        end
        chk("full_pp_empty", 37'(out_valid), 37'(0));
        out_ready = 1'b0;

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) push_word(17'(32'h60 + i), 20'(32'h21 + i));
        mce = 1'b0; msel = 3'd4; maddr = '0;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 37'(out_valid), 37'(0));
        chk("arst_addr", 37'(out_addr), 37'(0));
        chk("arst_data", 37'(out_data), 37'(0));
        chk("arst_t", 37'(mdata_r), 37'(0));
        tick();
        reset = 1'b1;
        push_word(17'h00055, 20'h7);
        mce = 1'b0; msel = 3'd0; maddr = '0; #1;
        chk("post_rst_valid", 37'(out_valid), 37'(1));
        chk("post_rst_data", 37'(out_data), 37'(7));
        chk("post_rst_addr", 37'(out_addr), 37'(17'h55));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset    = 1'b1;
            mce      = 1'($urandom_range(0, 1));
            msel     = 3'($urandom_range(0, 7));
            if (mce && ($urandom_range(0, 2) == 0)) msel = 3'd5;
            maddr    = pick_addr();
            mdata_w  = 20'($urandom);
            ld_valid = 1'($urandom_range(0, 1));
            ld_sel   = 3'($urandom_range(0, 5));
            ld_addr  = pick_addr();
            ld_data  = 20'($urandom);
            out_ready = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 85 : 30));
            flag_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            tick();
        end
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rnn_param_mem.md
# rnn_param_mem

Memory responder for the RNN datapath's parameter/result interface (`mce`, `msel`, `maddr`, `mdata_r`, `mdata_w`).
- Holds the weight, bias and time-step-count regions the RNN reads, loaded beforehand through a host load port.
- Captures every result word the RNN writes (msel=101) into an output FIFO drained by a valid/ready stream.
- Sits directly beside the RNN core. The RNN cannot stall, so reads are zero-wait and writes are never back-pressured.

## Interface
Parameters:
- `DEPTH`, 4 — output FIFO depth in words, power of two, ≥2.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `mce` in 1 — RNN memory enable (RNN busy).
- `msel` in 3 — region select: 000 W_x, 001 b_x, 010 W_h, 011 b_h, 100 T count, 101 result write; 110/111 invalid.
- `maddr` in 17 — word address within the region.
- `mdata_w` in 20 — result data, msel=101 only.
- `mdata_r` out 20 — read data.
- `ld_valid` in 1 — host load request.
- `ld_ready` out 1 — load accepted when `ld_valid & ld_ready`.
- `ld_sel` in 3 — load region, same encoding as `msel`.
- `ld_addr` in 17 — load word address.
- `ld_data` in 20 — load data.
- `out_valid` out 1 — FIFO head valid.
- `out_ready` in 1 — consumer pops head.
- `out_addr` out 17 — head result address, `{t[10:0],h[5:0]}`.
- `out_data` out 20 — head result data.
- `ovf` out 1 — sticky FIFO overflow flag.
- `err` out 1 — sticky illegal-access flag.
- `flag_clr` in 1 — synchronous clear of `ovf` and `err`.

## Operation
Region ranges. An address outside its region is illegal.
- W_x: 2048 words, `maddr[16:11]==0`.
- b_x, b_h: 64 words each, `maddr[16:6]==0`.
- W_h: 4096 words, `maddr[16:12]==0`.
- T: one word, `maddr==0`.
- Result region (101): write-only, any address; the address is forwarded, not stored.

Reads:
- `mdata_r` is combinational from `msel`/`maddr` and the stored arrays, independent of `mce`.
- Illegal region, out-of-range address, or msel=101 → `mdata_r`=0.
- `err` is set only if `mce`=1 during such a read.

Writes from the RNN:
- Every cycle with `mce`=1 and `msel`=101 pushes `{maddr, mdata_w}` into the FIFO. No other write path exists on the RNN side.

Loads:
- `ld_ready` = ~`mce` (combinational). No load while the RNN runs.
- An accepted load writes `ld_data` into region `ld_sel` at `ld_addr`.
- Loads with `ld_sel` ∈ {101, 110, 111} or an out-of-range address are dropped and set `err`.

FIFO:
- Push and pop in the same cycle are both honoured.
- If full with no pop: a push is dropped and sets `ovf`. Contents are unchanged.
- If full and popping: the push is accepted and occupancy stays `DEPTH`.
- Pointers wrap modulo `DEPTH`.
- `out_addr`/`out_data` hold the head word; they are stable while `out_valid & ~out_ready`.

Flags:
- `ovf`/`err` set on the offending edge and stay set until `flag_clr`.
- If `flag_clr` and a new set event occur in the same cycle, set wins.

Reset (`reset`=0, asynchronous):
- FIFO emptied: `out_valid`=0; `out_addr`, `out_data` = 0.
- `ovf`=0, `err`=0, T=0.
- W_x, b_x, W_h, b_h are not cleared.
- Reset during an RNN run or mid-drain discards FIFO contents. The first push after release lands at the head.

## Timing
- Read latency: 0 cycles. `mdata_r` settles within the same cycle `msel`/`maddr` change, before the next rising edge.
- Load: written at the accepting edge, visible on `mdata_r` from the following cycle.
- FIFO: a push at edge N gives `out_valid`=1 after edge N; a pop at edge M presents the next entry after M.
- Sustained rate: one push and one pop per cycle.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- Load W_x[5]=0x12345, W_h[4095]=0xFFFFF, T=3 with `mce`=0; then `mce`=1, msel=000/maddr=5 → `mdata_r`=0x12345. msel=010/maddr=4095 → 0xFFFFF. msel=100/maddr=0 → 3. `err`=0.
- `mce`=1, msel=001, maddr=64 → `mdata_r`=0 and `err`=1 after the edge. `flag_clr` pulse → `err`=0. Same read with `mce`=0 → `err` stays 0.
- `ld_valid`=1 while `mce`=1 → `ld_ready`=0, storage unchanged. Drop `mce` → load accepted on the next edge.
- `DEPTH`=4, `out_ready`=0, five pushes (maddr 0x00040..0x00044, data 1..5) → `ovf`=1; drain yields addrs 0x40–0x43, data 1–4 in order.
- Full FIFO, simultaneous push (data 9) and pop → occupancy stays 4, `ovf`=0, and 9 emerges last.
- Assert `reset`=0 with 3 entries queued → `out_valid`=0 immediately (asynchronous). After release, a push of data 7 appears at the head next cycle.
